multicycle_sequencer: RTL and testbench
=======================================

Name: multicycle_sequencer

Overview:
- FSM that drives the multi-cycle RISC-V core through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
- Generates the write enables for the instruction register, PC and register bank, plus the datapath mux selects.
- Handshakes with instruction/data memory and counts retired instructions.
- Sits between the top-level core wrapper and the datapath (register bank, ALU, PC, memory interface).

Parameters:
MEM_TIMEOUT, 255, max cycles to wait for mem_ready before faulting (1..65535)
CNT_W, 32, width of retired-instruction counter

Ports:
stage_clk  in  1  single system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  begin execution from IDLE
opcode  in  7  IR[6:0], valid from DECODE onward
rd  in  5  IR[11:7] destination register index
branch_taken  in  1  ALU compare result, sampled in EXECUTE
mem_ready  in  1  memory completes the current request this cycle
mem_req  out  1  memory request active
mem_we  out  1  store request (valid with mem_req)
mem_addr_sel  out  1  0 = PC, 1 = ALU result
ir_we  out  1  load IR this cycle
pc_we  out  1  update PC this cycle
pc_sel  out  1  0 = PC+4, 1 = ALU target
rf_we  out  1  register bank write enable
wb_sel  out  2  0 = ALU, 1 = memory data, 2 = PC+4
busy  out  1  state not IDLE/HALT
halted  out  1  in HALT
fault  out  2  0 none, 1 illegal opcode, 2 memory timeout
state_out  out  3  current state encoding
instr_count  out  CNT_W  retired instructions

Behaviour:
- Reset (reset=0, async): state=IDLE, timeout counter=0, instr_count=0, fault=0. All enables, selects and status outputs are 0.
- States: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, HALT=6.
- IDLE: start=1 -> FETCH next cycle. start is ignored in every other state.
- FETCH: mem_req=1, mem_we=0, mem_addr_sel=0. When mem_ready=1: ir_we=1 in the same cycle (Mealy), then -> DECODE.
- DECODE: classify opcode.
  - SYSTEM 1110011 -> HALT, fault stays 0.
  - Unlisted opcode -> HALT, fault=1.
  - Otherwise -> EXECUTE.
  - Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111.
- EXECUTE:
  - LOAD/STORE -> MEMORY.
  - BRANCH: pc_we=1, pc_sel=branch_taken, retire, -> FETCH.
  - All other classes -> WRITEBACK.
- MEMORY: mem_req=1, mem_addr_sel=1, mem_we=1 only for STORE. On mem_ready:
  - STORE: pc_we=1, pc_sel=0, retire, -> FETCH.
  - LOAD -> WRITEBACK.
- WRITEBACK:
  - rf_we=1 only if rd!=0; writes to x0 are suppressed.
  - wb_sel: 1 for LOAD, 2 for JAL/JALR, 0 otherwise.
  - pc_we=1, pc_sel=1 for JAL/JALR, 0 otherwise.
  - Retire, -> FETCH.
- Instruction class is latched in DECODE and held until retire; opcode changes after DECODE are ignored.
- Retire: instr_count += 1 on the retire cycle, wrapping from all-ones to 0.
- Latency: fetch with immediate mem_ready:
  - ALU op = 4 cycles (F, D, E, W).
  - Branch and JAL each complete in their listed states: branch = 3 cycles, JAL = 4.
  - Load = 5 cycles, store = 4 cycles.
- Timeout:
  - Counter clears on entering FETCH/MEMORY and increments each cycle mem_ready=0.
  - Reaching MEM_TIMEOUT -> HALT, fault=2, mem_req drops next cycle.
  - mem_ready in the same cycle as the limit wins: normal completion.
- mem_ready outside FETCH/MEMORY is ignored.
- HALT: all enables 0, halted=1. Left only by reset.
- Reset mid-operation: immediate return to IDLE. Any pending memory request is abandoned and no write enable is asserted.
- busy=1 in states 1–5. Status outputs are decoded from registered state (Moore). ir_we/pc_we/rf_we are combinational from state + inputs and glitch-free relative to stage_clk.

Decomposition:
- Package multicycle_pkg: state encodings, opcode constants, instruction-class enum (ALU, LOAD, STORE, BRANCH, JUMP, UPPER, SYSTEM, ILLEGAL), wb_sel and fault encodings.
- One sub-module, opcode_classifier: combinational opcode -> class. Reused by the testbench scoreboard.

Test Plan:
- Reset, start, ADD (0110011, rd=5), mem_ready immediate -> states 1,2,3,5; ir_we in cycle 1; rf_we=1 and wb_sel=0 in WRITEBACK; instr_count=1.
- LOAD rd=0 with mem_ready delayed 3 cycles in MEMORY -> mem_req held 4 cycles, wb_sel=1, rf_we=0 (x0), pc_we=1.
- STORE followed by BRANCH with branch_taken=1 -> mem_we=1 only in MEMORY; branch pc_we=1 with pc_sel=1; no WRITEBACK visited; instr_count=2.
- JAL rd=1 -> wb_sel=2, rf_we=1, pc_sel=1; then opcode 1111111 -> HALT, fault=1, start ignored, outputs stable for 10 cycles.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> HALT after 4 wait cycles, fault=2; mem_ready=1 exactly at limit -> DECODE instead.
- reset asserted while in MEMORY with mem_req=1 -> same cycle state=IDLE, mem_req=0, instr_count=0; instr_count preset to 0xFFFFFFFF plus one retire -> wraps to 0.

Source files
------------

// File: rtl/multicycle_pkg.sv
// Shared definitions for the multi-cycle RISC-V sequencer.
//   state_e        : FSM state encodings (also driven on state_out)
//   instr_class_e  : instruction class produced by opcode_classifier
//   wb_sel_e       : register-bank write-back source select
//   fault_e        : fault codes reported when the FSM halts
//   OP_*           : RV32I major opcodes (IR[6:0])
package multicycle_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALT      = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BRANCH,
        CLS_JUMP, CLS_UPPER, CLS_SYSTEM, CLS_ILLEGAL
    } instr_class_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_e;

    typedef enum logic [1:0] {
        FLT_NONE    = 2'd0,
        FLT_ILLEGAL = 2'd1,
        FLT_TIMEOUT = 2'd2
    } fault_e;

    localparam logic [6:0] OP_ALU_R  = 7'b0110011;
    localparam logic [6:0] OP_ALU_I  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // Wait-cycle counter width; covers MEM_TIMEOUT up to 65535.
    localparam int TMO_W = 16;

endpackage

// File: rtl/opcode_classifier.sv
// Combinational opcode -> instruction class decode.
//   opcode : IR[6:0]
//   cls    : instruction class; anything not listed is CLS_ILLEGAL
module opcode_classifier
    import multicycle_pkg::*;
(
    input  logic [6:0]   opcode,
    output instr_class_e cls
);

    always_comb begin
        cls = CLS_ILLEGAL;
        case (opcode)
            OP_ALU_R, OP_ALU_I: cls = CLS_ALU;
            OP_LOAD:            cls = CLS_LOAD;
            OP_STORE:           cls = CLS_STORE;
            OP_BRANCH:          cls = CLS_BRANCH;
            OP_JAL, OP_JALR:    cls = CLS_JUMP;
            OP_LUI, OP_AUIPC:   cls = CLS_UPPER;
            OP_SYSTEM:          cls = CLS_SYSTEM;
            default:            cls = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Control FSM for the multi-cycle RISC-V core:
// FETCH -> DECODE -> EXECUTE -> [MEMORY] -> [WRITEBACK] -> FETCH.
//   stage_clk, reset          : clock, async active-low reset
//   start                     : leave IDLE
//   opcode, rd                : IR fields (opcode only sampled in DECODE)
//   branch_taken, mem_ready   : datapath / memory status
//   mem_req/mem_we/mem_addr_sel : memory request interface
//   ir_we, pc_we, pc_sel, rf_we, wb_sel : datapath enables and selects
//   busy, halted, fault, state_out      : Moore status from registered state
//   instr_count               : retired-instruction counter (wraps)
module multicycle_sequencer
    import multicycle_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             stage_clk,
    input  logic             reset,
    input  logic             start,
    input  logic [6:0]       opcode,
    input  logic [4:0]       rd,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             ir_we,
    output logic             pc_we,
    output logic             pc_sel,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic             busy,
    output logic             halted,
    output logic [1:0]       fault,
    output logic [2:0]       state_out,
    output logic [CNT_W-1:0] instr_count
);

    // Last wait count before the limit: a not-ready cycle seen here is the
    // MEM_TIMEOUT-th wait and faults; a ready cycle here still completes.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    state_e            state_q, state_d;
    fault_e            fault_q, fault_d;
    instr_class_e      cls_q, cls_dec;
    logic [TMO_W-1:0]  tmo_q;
    logic              retire;

    opcode_classifier u_cls (
        .opcode (opcode),
        .cls    (cls_dec)
    );

    always_comb begin
        state_d      = state_q;
        fault_d      = fault_q;
        retire       = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = 1'b0;
        rf_we        = 1'b0;
        wb_sel       = WB_ALU;
        case (state_q)
            S_IDLE: if (start) state_d = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_HALT;
                    fault_d = FLT_TIMEOUT;
                end
            end
            S_DECODE: begin
                case (cls_dec)
                    CLS_SYSTEM:  state_d = S_HALT;
                    CLS_ILLEGAL: begin
                        state_d = S_HALT;
                        fault_d = FLT_ILLEGAL;
                    end
                    default:     state_d = S_EXECUTE;
                endcase
            end
            S_EXECUTE: begin
                case (cls_q)
                    CLS_LOAD, CLS_STORE: state_d = S_MEMORY;
                    CLS_BRANCH: begin
                        pc_we   = 1'b1;
                        pc_sel  = branch_taken;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    default: state_d = S_WRITEBACK;
                endcase
            end
            S_MEMORY: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (cls_q == CLS_STORE);
                if (mem_ready) begin
                    if (cls_q == CLS_STORE) begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_HALT;
                    fault_d = FLT_TIMEOUT;
                end
            end
            S_WRITEBACK: begin
                rf_we   = (rd != 5'd0);
                pc_we   = 1'b1;
                pc_sel  = (cls_q == CLS_JUMP);
                retire  = 1'b1;
                state_d = S_FETCH;
                if (cls_q == CLS_LOAD)      wb_sel = WB_MEM;
                else if (cls_q == CLS_JUMP) wb_sel = WB_PC4;
            end
            default: ;  // HALT: only reset leaves
        endcase
    end

    always_ff @(posedge stage_clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            fault_q     <= FLT_NONE;
            cls_q       <= CLS_ILLEGAL;
            tmo_q       <= '0;
            instr_count <= '0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            if (state_q == S_DECODE) cls_q <= cls_dec;
            // Any state change (including entry to FETCH/MEMORY) restarts the wait count.
            if (state_d != state_q)
                tmo_q <= '0;
            else if ((state_q == S_FETCH || state_q == S_MEMORY) && !mem_ready)
                tmo_q <= tmo_q + TMO_W'(1);
            if (retire) instr_count <= instr_count + CNT_W'(1);
        end
    end

    assign state_out = state_q;
    assign busy      = (state_q != S_IDLE) && (state_q != S_HALT);
    assign halted    = (state_q == S_HALT);
    assign fault     = fault_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer. Each instruction pushes its
// expected per-cycle output vectors (with the inputs to drive) onto a
// queue; drain() pops them, drives the inputs and compares mid-cycle.
module tb_multicycle_sequencer;
    import multicycle_pkg::*;

    localparam int CNT_W = 3;
    localparam int TMO   = 4;
    localparam logic [6:0] JUNK = 7'b1111111;

    logic             stage_clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [6:0]       opcode = '0;
    logic [4:0]       rd = '0;
    logic             branch_taken = 1'b0;
    logic             mem_ready = 1'b0;
    logic             mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel, rf_we;
    logic [1:0]       wb_sel, fault;
    logic             busy, halted;
    logic [2:0]       state_out;
    logic [CNT_W-1:0] instr_count;
    instr_class_e     tb_cls;
    logic [15:0]      obs;

    always #5 stage_clk = ~stage_clk;

    multicycle_sequencer #(.MEM_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
        .stage_clk(stage_clk), .reset(reset), .start(start), .opcode(opcode), .rd(rd),
        .branch_taken(branch_taken), .mem_ready(mem_ready), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_we(ir_we), .pc_we(pc_we),
        .pc_sel(pc_sel), .rf_we(rf_we), .wb_sel(wb_sel), .busy(busy), .halted(halted),
        .fault(fault), .state_out(state_out), .instr_count(instr_count)
    );

    opcode_classifier u_ref (.opcode(opcode), .cls(tb_cls));

    assign obs = {state_out, busy, halted, fault, mem_req, mem_we, mem_addr_sel,
                  ir_we, pc_we, pc_sel, rf_we, wb_sel};

    typedef struct packed {
        logic         st;
        logic         rdy;
        logic         tkn;
        logic [6:0]   op;
        logic         chk_cls;
        instr_class_e cls;
        logic [15:0]  exp;
    } step_t;

    step_t            sb[$];
    int               n_chk = 0, n_pass = 0, n_fail = 0, cyc = 0;
    logic [CNT_W-1:0] exp_cnt = '0;

    function automatic logic [15:0] ov(state_e s, logic mreq, logic mwe, logic asel,
                                       logic irwe, logic pcwe, logic pcsel, logic rfwe,
                                       logic [1:0] wb, logic [1:0] flt);
        logic bsy, hlt;
        bsy = (s != S_IDLE) && (s != S_HALT);
        hlt = (s == S_HALT);
        return {s, bsy, hlt, flt, mreq, mwe, asel, irwe, pcwe, pcsel, rfwe, wb};
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_chk++;
        assert (o === e) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic push(input logic s, input logic r, input logic t, input logic [6:0] op,
                        input logic [15:0] e, input logic cc = 1'b0,
                        input instr_class_e c = CLS_ALU);
        step_t x;
        x.st = s; x.rdy = r; x.tkn = t; x.op = op; x.chk_cls = cc; x.cls = c; x.exp = e;
        sb.push_back(x);
    endtask

    task automatic drain();
        step_t s;
        while (sb.size() > 0) begin
            s = sb.pop_front();
            start = s.st; mem_ready = s.rdy; branch_taken = s.tkn; opcode = s.op;
            @(negedge stage_clk);
            chk($sformatf("cyc%0d_state%0d", cyc, s.exp[15:13]), 32'(obs), 32'(s.exp));
            if (s.chk_cls) chk("classifier", 32'(tb_cls), 32'(s.cls));
            @(posedge stage_clk); #1;
            cyc++;
        end
        start = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0; start = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0;
        repeat (2) @(posedge stage_clk);
        #1;
        chk("reset_outputs", 32'(obs), 32'd0);
        chk("reset_count", 32'(instr_count), 32'd0);
        exp_cnt = '0;
        reset = 1'b1;
    endtask

    task automatic do_start();
        push(1'b0, 1'b1, 1'b0, 7'd0, ov(S_IDLE, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0));
        push(1'b1, 1'b0, 1'b0, 7'd0, ov(S_IDLE, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0));
    endtask

    // fw/mw: not-ready cycles before mem_ready in FETCH/MEMORY.
    // abort: stop while still waiting in MEMORY (no completion, no retire).
    task automatic run_instr(input logic [6:0] op, input logic [4:0] r, input instr_class_e c,
                             input int fw, input int mw, input logic tkn,
                             input logic abort = 1'b0);
        logic is_br, is_st, is_ld, is_j;
        logic [1:0] wb;
        is_br = (c == CLS_BRANCH);
        is_st = (c == CLS_STORE);
        is_ld = (c == CLS_LOAD);
        is_j  = (c == CLS_JUMP);
        wb    = is_ld ? 2'd1 : (is_j ? 2'd2 : 2'd0);
        rd    = r;
        for (int i = 0; i < fw; i++)
            push(0, 0, 0, op, ov(S_FETCH, 1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0));
        push(0, 1, 0, op, ov(S_FETCH, 1, 0, 0, 1, 0, 0, 0, 2'd0, 2'd0));
        push(0, 0, 0, op, ov(S_DECODE, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0), 1'b1, c);
        if (c == CLS_SYSTEM || c == CLS_ILLEGAL) begin
            // start held high and mem_ready toggling: HALT must not move
            for (int i = 0; i < 10; i++)
                push(1, i[0], 0, op, ov(S_HALT, 0, 0, 0, 0, 0, 0, 0, 2'd0,
                                        (c == CLS_ILLEGAL) ? 2'd1 : 2'd0));
        end else begin
            // opcode scrambled after DECODE; mem_ready high where it must be ignored
            push(0, 1, tkn, JUNK, ov(S_EXECUTE, 0, 0, 0, 0, is_br, is_br & tkn, 0, 2'd0, 2'd0));
            if (is_br) exp_cnt++;
            else begin
                if (is_ld || is_st) begin
                    for (int i = 0; i < mw; i++)
                        push(0, 0, 0, JUNK, ov(S_MEMORY, 1, is_st, 1, 0, 0, 0, 0, 2'd0, 2'd0));
                    if (!abort)
                        push(0, 1, 0, JUNK, ov(S_MEMORY, 1, is_st, 1, 0, is_st, 0, 0, 2'd0, 2'd0));
                end
                if (!abort && !is_st)
                    push(0, 1, 0, JUNK, ov(S_WRITEBACK, 0, 0, 0, 0, 1, is_j, r != 5'd0, wb, 2'd0));
                if (!abort) exp_cnt++;
            end
        end
        drain();
        if (!abort) chk("instr_count", 32'(instr_count), 32'(exp_cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Basic flow, all classes, counter wrap (CNT_W=3: 8 retires -> 0), illegal halt
        do_reset();
        do_start();
        run_instr(OP_ALU_R,  5'd5, CLS_ALU,    0, 0, 1'b0);
        run_instr(OP_LOAD,   5'd0, CLS_LOAD,   1, 3, 1'b0);
        run_instr(OP_STORE,  5'd9, CLS_STORE,  0, 0, 1'b0);
        run_instr(OP_BRANCH, 5'd0, CLS_BRANCH, 0, 0, 1'b1);
        run_instr(OP_LUI,    5'd3, CLS_UPPER,  0, 0, 1'b0);
        run_instr(OP_BRANCH, 5'd0, CLS_BRANCH, 2, 0, 1'b0);
        run_instr(OP_JAL,    5'd1, CLS_JUMP,   0, 0, 1'b0);
        run_instr(OP_JALR,   5'd0, CLS_JUMP,   0, 0, 1'b0);
        run_instr(JUNK,      5'd0, CLS_ILLEGAL, 0, 0, 1'b0);

        // Reset asserted mid-MEMORY with a request outstanding
        do_reset();
        do_start();
        run_instr(OP_ALU_I,  5'd3, CLS_ALU,    0, 0, 1'b0);
        run_instr(OP_LOAD,   5'd4, CLS_LOAD,   0, 2, 1'b0, 1'b1);
        chk("pre_reset_state", 32'(state_out), 32'(S_MEMORY));
        chk("pre_reset_memreq", 32'(mem_req), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("async_reset_outputs", 32'(obs), 32'd0);
        chk("async_reset_count", 32'(instr_count), 32'd0);

        // FETCH timeout: 4 not-ready cycles -> HALT, fault=2, mem_req dropped
        do_reset();
        do_start();
        for (int i = 0; i < TMO; i++)
            push(0, 0, 0, OP_ALU_R, ov(S_FETCH, 1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0));
        for (int i = 0; i < 3; i++)
            push(1, 1, 0, OP_ALU_R, ov(S_HALT, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd2));
        drain();

        // mem_ready on the limit cycle completes normally; then SYSTEM halts cleanly
        do_reset();
        do_start();
        run_instr(OP_AUIPC,  5'd7, CLS_UPPER,  TMO - 1, 0, 1'b0);
        run_instr(OP_SYSTEM, 5'd0, CLS_SYSTEM, 0, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
